// File: rtl/urv_writeback.sv
// Writeback stage: selects the rd value, formats load data and drives the register-file write port.
// Holds the pipeline while a load/store waits on data memory; a wait counter aborts hung accesses.
module urv_writeback #(
  parameter int unsigned g_mem_timeout   = 255,
  parameter int unsigned g_timeout_width = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_req_o,
  output logic        w_bus_err_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LD, S_WAIT_ST} state_t;

  localparam logic [g_timeout_width-1:0] TMO_LAST =
    (g_mem_timeout == 0) ? '0 : g_timeout_width'(g_mem_timeout - 1);

  state_t                     state_q, state_d;
  logic [g_timeout_width-1:0] cnt_q, cnt_d;
  logic [2:0]                 fun_q, fun_d;
  logic [1:0]                 addr_q, addr_d;
  logic [4:0]                 rd_q, rd_d;
  logic                       rdw_q, rdw_d;

  logic        ld_req, st_req, waiting, done, tmo_hit, timeout, stall, is_load;
  logic [2:0]  fun;
  logic [1:0]  addr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val, src_val;
  logic        unused_addr;

  assign unused_addr = ^x_dm_addr_i[31:2];

  always_comb begin
    ld_req  = x_valid_i & x_load_i;
    st_req  = x_valid_i & x_store_i;
    waiting = (state_q != S_IDLE);
    done    = (state_q == S_WAIT_LD) ? dm_load_done_i : dm_store_done_i;
    // Zero timeout disables the abort entirely; the counter just saturates.
    tmo_hit = (g_mem_timeout != 0) && (cnt_q == TMO_LAST);
    timeout = waiting & ~done & tmo_hit;

    state_d = state_q;
    cnt_d   = cnt_q;
    fun_d   = fun_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    rdw_d   = rdw_q;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_req && !dm_load_done_i) begin
          state_d = S_WAIT_LD;
          stall   = 1'b1;
        end else if (st_req && !dm_store_done_i) begin
          state_d = S_WAIT_ST;
          stall   = 1'b1;
        end
        if (state_d != S_IDLE) begin
          cnt_d  = '0;
          fun_d  = x_fun_i;
          addr_d = x_dm_addr_i[1:0];
          rd_d   = x_rd_i;
          rdw_d  = x_rd_write_i;
        end
      end
      default: begin
        if (done || timeout) state_d = S_IDLE;
        else                 stall   = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    endcase
  end

  // While waiting, formatting and destination come from the values latched on entry.
  always_comb begin
    fun  = waiting ? fun_q  : x_fun_i;
    addr = waiting ? addr_q : x_dm_addr_i[1:0];

    case (addr)
      2'd0:    byte_v = dm_data_l_i[7:0];
      2'd1:    byte_v = dm_data_l_i[15:8];
      2'd2:    byte_v = dm_data_l_i[23:16];
      default: byte_v = dm_data_l_i[31:24];
    endcase
    half_v = addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

    case (fun)
      3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  ld_val = {24'd0, byte_v};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = dm_data_l_i;
    endcase

    case (x_rd_source_i)
      2'd0:    src_val = x_rd_value_i;
      2'd1:    src_val = x_shifter_rd_value_i;
      2'd2:    src_val = x_multiply_rd_value_i;
      default: src_val = '0;
    endcase

    is_load       = (state_q == S_WAIT_LD) || (state_q == S_IDLE && ld_req);
    rf_rd_value_o = is_load ? ld_val : src_val;
    rf_rd_o       = waiting ? rd_q : x_rd_i;

    case (state_q)
      S_IDLE:    rf_rd_write_o = ld_req ? (x_rd_write_i & dm_load_done_i)
                                        : (x_valid_i & x_rd_write_i & ~x_store_i);
      S_WAIT_LD: rf_rd_write_o = rdw_q & dm_load_done_i;
      default:   rf_rd_write_o = 1'b0;
    endcase
    rf_rd_write_o = rf_rd_write_o & rst_n_i;
    w_stall_req_o = stall & rst_n_i;
    w_bus_err_o   = timeout & rst_n_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fun_q   <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      rdw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fun_q   <= fun_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      rdw_q   <= rdw_d;
    end
  end

endmodule
